tom_dram_bridge: RTL and testbench

- Sits directly downstream of the Tom wrapper's DRAM pins: RAS/CAS (active-low), MA, WE_n, OE_n and the data bus.
- Converts Tom's page-mode DRAM cycles into single-word requests on a synchronous 64-bit memory port (SDRAM/DDR arbiter side).
- Returns read data onto Tom's data-in bus and drives Tom's ram_ready.
- Also filters CAS-before-RAS refresh cycles and flags protocol overruns.

---
 rtl/tom_mem_pkg.sv | 22 ++
 rtl/tom_dram_bridge_if.sv | 23 ++
 rtl/tom_dram_edge.sv | 39 +++
 rtl/tom_dram_bridge.sv | 165 ++++++++++++++++
 tb/tb_tom_dram_bridge.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/tom_mem_pkg.sv
// Shared types for the Tom DRAM bridge: FSM state encoding, default geometry
// and the packed single-word memory request.
package tom_mem_pkg;

    localparam int ROW_BITS_DEF = 9;
    localparam int COL_BITS_DEF = 9;
    localparam int ADDR_W_DEF   = 1 + ROW_BITS_DEF + COL_BITS_DEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    typedef struct packed {
        logic                  we;
        logic [7:0]            be;
        logic [ADDR_W_DEF-1:0] addr;
        logic [63:0]           wdata;
    } mem_req_t;

endpackage

// File: rtl/tom_dram_bridge_if.sv
// Synchronous 64-bit single-word memory port between the bridge (master)
// and the SDRAM/DDR arbiter (slave).
interface tom_dram_bridge_if #(
    parameter int ADDR_W = 19
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_be;
    logic [63:0]       mem_wdata;
    logic              mem_ack;
    logic [63:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/tom_dram_edge.sv
// Per-bank registered edge detector for the active-low RAS/CAS strobes;
// an edge is a mismatch between the live pin and last cycle's value.
module tom_dram_edge (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic [1:0] ras_n,
    input  logic [1:0] cas_n,
    output logic [1:0] r_ras,
    output logic [1:0] r_cas,
    output logic [1:0] ras_fall,
    output logic [1:0] ras_rise,
    output logic [1:0] cas_fall,
    output logic [1:0] cas_rise
);
    logic [1:0] r_ras_reg;
    logic [1:0] r_cas_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            always_ff @(posedge clk_sys) begin
                if (reset) begin
                    r_ras_reg[gi] <= 1'b1;
                    r_cas_reg[gi] <= 1'b1;
                end else begin
                    r_ras_reg[gi] <= ras_n[gi];
                    r_cas_reg[gi] <= cas_n[gi];
                end
            end

            assign ras_fall[gi] =  r_ras_reg[gi] & ~ras_n[gi];
            assign ras_rise[gi] = ~r_ras_reg[gi] &  ras_n[gi];
            assign cas_fall[gi] =  r_cas_reg[gi] & ~cas_n[gi];
            assign cas_rise[gi] = ~r_cas_reg[gi] &  cas_n[gi];
        end
    endgenerate

    assign r_ras = r_ras_reg;
    assign r_cas = r_cas_reg;
endmodule

// File: rtl/tom_dram_bridge.sv
// Turns Tom's page-mode RAS/CAS DRAM cycles into single-word requests on a
// synchronous 64-bit memory port; also counts CBR refreshes and flags overruns.
module tom_dram_bridge
    import tom_mem_pkg::*;
#(
    parameter int ROW_BITS = ROW_BITS_DEF,
    parameter int COL_BITS = COL_BITS_DEF,
    parameter int ADDR_W   = 1 + ROW_BITS + COL_BITS
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic [1:0]           ras_n,
    input  logic [1:0]           cas_n,
    input  logic [10:0]          ma,
    input  logic [7:0]           we_n,
    input  logic [1:0]           oe_n,
    input  logic [63:0]          dbus_wr,
    output logic [63:0]          dbus_rd,
    output logic                 dbus_rd_en,
    output logic                 ram_ready,
    tom_dram_bridge_if.master    mem,
    output logic [15:0]          refresh_cnt,
    output logic                 overrun
);
    logic [1:0] r_ras;
    logic [1:0] r_cas;
    logic [1:0] ras_fall;
    logic [1:0] ras_rise;
    logic [1:0] cas_fall;
    logic [1:0] cas_rise;

    tom_dram_edge u_edge (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .ras_n    (ras_n),
        .cas_n    (cas_n),
        .r_ras    (r_ras),
        .r_cas    (r_cas),
        .ras_fall (ras_fall),
        .ras_rise (ras_rise),
        .cas_fall (cas_fall),
        .cas_rise (cas_rise)
    );

    state_t              state_reg;
    state_t              state_next;
    logic                page_open_reg;
    logic                bank_reg;
    logic [ROW_BITS-1:0] row_reg;
    mem_req_t            req_reg;
    logic [63:0]         rdata_reg;
    logic                overrun_reg;
    logic [15:0]         refresh_cnt_reg;

    // Event decode; bank 0 wins when both banks strobe in the same cycle.
    logic ras_bank;
    logic cas_bank;
    logic ras_open_ev;
    logic cas_ev;
    logic cbr_ev;
    logic busy_ev;
    logic start_ev;
    logic both_low;

    assign ras_bank    = ~ras_fall[0];
    assign cas_bank    = ~cas_fall[0];
    assign ras_open_ev = (|ras_fall) & cas_n[ras_bank];
    assign cas_ev      = |cas_fall;
    assign cbr_ev      = cas_ev & ras_n[cas_bank];
    assign busy_ev     = cas_ev & ~cbr_ev & (state_reg != IDLE);
    assign start_ev    = cas_ev & ~cbr_ev & (state_reg == IDLE) & page_open_reg;
    assign both_low    = ((|ras_fall) & (ras_n == 2'b00)) |
                         (cas_ev & (cas_n == 2'b00));

    // Row/bank latch for page mode.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            page_open_reg <= 1'b0;
            bank_reg      <= 1'b0;
            row_reg       <= '0;
        end else if (ras_open_ev) begin
            page_open_reg <= 1'b1;
            bank_reg      <= ras_bank;
            row_reg       <= ma[ROW_BITS-1:0];
        end else if (ras_rise[bank_reg]) begin
            page_open_reg <= 1'b0;
        end
    end

    // Request capture at CAS fall and read-data latch at ack.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            req_reg   <= '0;
            rdata_reg <= '0;
        end else begin
            if (start_ev) begin
                req_reg.we    <= |(~we_n);
                req_reg.be    <= ~we_n;
                req_reg.addr  <= ADDR_W_DEF'({bank_reg, row_reg, ma[COL_BITS-1:0]});
                req_reg.wdata <= dbus_wr;
            end
            if (state_reg == ISSUE && mem.mem_ack && !req_reg.we) begin
                rdata_reg <= mem.mem_rdata;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            overrun_reg     <= 1'b0;
            refresh_cnt_reg <= '0;
        end else begin
            if (busy_ev || both_low) begin
                overrun_reg <= 1'b1;
            end
            if (cbr_ev) begin
                refresh_cnt_reg <= refresh_cnt_reg + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_ev)          state_next = ISSUE;
            ISSUE:   if (mem.mem_ack)       state_next = HOLD;
            HOLD:    if (r_cas[bank_reg])   state_next = IDLE;
            default:                        state_next = IDLE;
        endcase
    end

    // HOLD drops ready in the cycle the registered CAS is seen high again.
    always_comb begin
        mem.mem_req = 1'b0;
        ram_ready   = 1'b0;
        dbus_rd_en  = 1'b0;
        case (state_reg)
            ISSUE: mem.mem_req = 1'b1;
            HOLD: begin
                ram_ready  = ~r_cas[bank_reg];
                dbus_rd_en = ~r_cas[bank_reg] & ~req_reg.we & ~oe_n[bank_reg];
            end
            default: ;
        endcase
    end

    assign mem.mem_we    = req_reg.we;
    assign mem.mem_be    = req_reg.be;
    assign mem.mem_addr  = req_reg.addr;
    assign mem.mem_wdata = req_reg.wdata;
    assign dbus_rd       = rdata_reg;
    assign refresh_cnt   = refresh_cnt_reg;
    assign overrun       = overrun_reg;

    logic unused_ok;
    assign unused_ok = &{1'b0, ma, r_ras, cas_rise};
endmodule

// File: tb/tb_tom_dram_bridge.sv
// Directed bench for tom_dram_bridge: table of page-mode CAS transactions plus
// hand sequences for CBR refresh, overrun and reset during a request.
module tb_tom_dram_bridge;
    logic        clk_sys = 1'b0;
    logic        reset;
    logic [1:0]  ras_n;
    logic [1:0]  cas_n;
    logic [10:0] ma;
    logic [7:0]  we_n;
    logic [1:0]  oe_n;
    logic [63:0] dbus_wr;
    logic [63:0] dbus_rd;
    logic        dbus_rd_en;
    logic        ram_ready;
    logic [15:0] refresh_cnt;
    logic        overrun;

    int tests  = 0;
    int failed = 0;

    tom_dram_bridge_if #(.ADDR_W(19)) mem_if ();

    tom_dram_bridge dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .ras_n       (ras_n),
        .cas_n       (cas_n),
        .ma          (ma),
        .we_n        (we_n),
        .oe_n        (oe_n),
        .dbus_wr     (dbus_wr),
        .dbus_rd     (dbus_rd),
        .dbus_rd_en  (dbus_rd_en),
        .ram_ready   (ram_ready),
        .mem         (mem_if),
        .refresh_cnt (refresh_cnt),
        .overrun     (overrun)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic        open;
        logic        bank;
        logic [10:0] ma_row;
        logic [10:0] ma_col;
        logic [7:0]  we_n;
        logic [63:0] wdata;
        logic [1:0]  oe_n;
        int          ack_wait;
        logic [63:0] rdata;
        logic [18:0] exp_addr;
        logic        exp_we;
        logic [7:0]  exp_be;
        logic        exp_en;
    } vec_t;

    vec_t vecs[7];

    task automatic step();
        @(posedge clk_sys);
        #2;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic open_row(input logic bank, input logic [10:0] row);
        ras_n = 2'b11;
        step();
        step();
        ma    = row;
        ras_n = bank ? 2'b01 : 2'b10;
        step();
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        if (v.open) open_row(v.bank, v.ma_row);
        // cycle N: CAS fall
        cas_n   = v.bank ? 2'b01 : 2'b10;
        ma      = v.ma_col;
        we_n    = v.we_n;
        dbus_wr = v.wdata;
        oe_n    = v.oe_n;
        step();
        chk("issue_req", mem_if.mem_req, 1);
        chk("issue_addr", mem_if.mem_addr, v.exp_addr);
        chk("issue_we", mem_if.mem_we, v.exp_we);
        chk("issue_be", mem_if.mem_be, v.exp_be);
        if (v.exp_we) chk("issue_wdata", mem_if.mem_wdata, v.wdata);
        chk("issue_ready", ram_ready, 0);
        chk("issue_rd_en", dbus_rd_en, 0);
        for (int i = 0; i < v.ack_wait; i++) begin
            step();
            chk("wait_req", mem_if.mem_req, 1);
        end
        mem_if.mem_ack   = 1'b1;
        mem_if.mem_rdata = v.rdata;
        step();
        mem_if.mem_ack   = 1'b0;
        mem_if.mem_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
        chk("hold_req", mem_if.mem_req, 0);
        chk("hold_ready", ram_ready, 1);
        chk("hold_rd_en", dbus_rd_en, v.exp_en);
        if (!v.exp_we) chk("hold_rdata", dbus_rd, v.rdata);
        cas_n = 2'b11;
        step();
        chk("exit_ready", ram_ready, 0);
        chk("exit_rd_en", dbus_rd_en, 0);
        step();
        $display("[TB] vec %0d bank=%0d addr=%h we=%0d be=%h", idx, v.bank,
                 mem_if.mem_addr, mem_if.mem_we, mem_if.mem_be);
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 11'h055, 11'h0AA, 8'hFF, 64'h0, 2'b10, 2,
                    64'h0123456789ABCDEF, 19'h0AAAA, 1'b0, 8'h00, 1'b1};
        vecs[1] = '{1'b0, 1'b0, 11'h000, 11'h001, 8'hFE, 64'hFF, 2'b10, 0,
                    64'h1111, 19'h0AA01, 1'b1, 8'h01, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 11'h000, 11'h002, 8'hFF, 64'h0, 2'b10, 0,
                    64'hDEADBEEFCAFEF00D, 19'h0AA02, 1'b0, 8'h00, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 11'h000, 11'h003, 8'hFF, 64'h0, 2'b11, 1,
                    64'h5555AAAA5555AAAA, 19'h0AA03, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 11'h000, 11'h7FF, 8'h00, 64'hA5A50F0F3C3C9696, 2'b11, 1,
                    64'h0, 19'h0ABFF, 1'b1, 8'hFF, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 11'h6C3, 11'h010, 8'hFF, 64'h0, 2'b01, 3,
                    64'hFEDCBA9876543210, 19'h58610, 1'b0, 8'h00, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 11'h000, 11'h155, 8'h0F, 64'h123456789ABCDEF0, 2'b01, 0,
                    64'h0, 19'h58755, 1'b1, 8'hF0, 1'b0};

        reset = 1'b1;
        ras_n = 2'b11;
        cas_n = 2'b11;
        ma = '0;
        we_n = 8'hFF;
        oe_n = 2'b11;
        dbus_wr = '0;
        mem_if.mem_ack = 1'b0;
        mem_if.mem_rdata = '0;
        step();
        step();
        reset = 1'b0;
        step();
        chk("rst_req", mem_if.mem_req, 0);
        chk("rst_ready", ram_ready, 0);
        chk("rst_rd_en", dbus_rd_en, 0);
        chk("rst_dbus_rd", dbus_rd, 0);
        chk("rst_addr", mem_if.mem_addr, 0);
        chk("rst_refresh", refresh_cnt, 0);
        chk("rst_overrun", overrun, 0);

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);
        chk("page_overrun", overrun, 0);
        chk("page_refresh", refresh_cnt, 0);

        // CBR refresh on bank 1 with RAS high
        ras_n = 2'b11;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            cas_n = 2'b01;
            step();
            chk("cbr_req_lo", mem_if.mem_req, 0);
            cas_n = 2'b11;
            step();
            chk("cbr_req_hi", mem_if.mem_req, 0);
        end
        chk("cbr_count", refresh_cnt, 5);
        chk("cbr_overrun", overrun, 0);
        $display("[TB] cbr refresh_cnt=%0d", refresh_cnt);

        // overrun: second CAS fall while the first request is unacknowledged
        open_row(1'b0, 11'h011);
        cas_n = 2'b10;
        ma = 11'h005;
        we_n = 8'hFF;
        oe_n = 2'b10;
        step();
        chk("ovr_req1", mem_if.mem_req, 1);
        cas_n = 2'b11;
        step();
        cas_n = 2'b10;
        ma = 11'h009;
        step();
        chk("ovr_flag", overrun, 1);
        chk("ovr_req_held", mem_if.mem_req, 1);
        chk("ovr_addr_kept", mem_if.mem_addr, 19'h02205);
        mem_if.mem_ack = 1'b1;
        mem_if.mem_rdata = 64'h77;
        step();
        mem_if.mem_ack = 1'b0;
        chk("ovr_ready", ram_ready, 1);
        cas_n = 2'b11;
        step();
        step();
        step();
        chk("ovr_single_req", mem_if.mem_req, 0);
        chk("ovr_sticky", overrun, 1);
        $display("[TB] overrun=%0d addr=%h", overrun, mem_if.mem_addr);

        // reset while a request is outstanding; late ack must be ignored
        cas_n = 2'b10;
        ma = 11'h006;
        step();
        chk("rmid_req", mem_if.mem_req, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rmid_req_lo", mem_if.mem_req, 0);
        chk("rmid_ready", ram_ready, 0);
        chk("rmid_overrun", overrun, 0);
        chk("rmid_refresh", refresh_cnt, 0);
        chk("rmid_dbus_rd", dbus_rd, 0);
        chk("rmid_addr", mem_if.mem_addr, 0);
        mem_if.mem_ack = 1'b1;
        mem_if.mem_rdata = 64'h99;
        step();
        mem_if.mem_ack = 1'b0;
        chk("rmid_late_ready", ram_ready, 0);
        chk("rmid_late_req", mem_if.mem_req, 0);
        step();
        chk("rmid_late_ready2", ram_ready, 0);
        chk("rmid_late_rd", dbus_rd, 0);
        $display("[TB] reset mid-issue req=%0d ready=%0d", mem_if.mem_req, ram_ready);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
